// File: rtl/instruction_decode_if.sv
// Bus between the instruction decode stage and its neighbours: the fetch
// unit, the register file and EXE. The master modport is the decoder's view;
// the slave modport is the view of the surrounding pipeline.
interface instruction_decode_if #(
    parameter int INSTR_W = 64,
    parameter int OP_W    = 16,
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 96
);
    // Fetch unit -> decode
    logic [INSTR_W-1:0] iInstruction;
    logic               iInstructionAvailable;
    logic [ADDR_W-1:0]  iIP;

    // Register file read ports
    logic [15:0]        oRFReadAddr0;
    logic [15:0]        oRFReadAddr1;
    logic [DATA_W-1:0]  iRFData0;
    logic [DATA_W-1:0]  iRFData1;

    // Decode -> EXE handshake
    logic [OP_W-1:0]    oOperation;
    logic [15:0]        oDestination;
    logic [DATA_W-1:0]  oSource0Value;
    logic [DATA_W-1:0]  oSource1Value;
    logic               oDecodeValid;
    logic               iEXEReady;

    // Return-address stack results back to fetch, plus status flags
    logic [ADDR_W-1:0]  oReturnAddress;
    logic               oSubroutineReturn;
    logic               oProgramEnd;
    logic               oStackError;
    logic               oOverrun;

    modport master (
        input  iInstruction, iInstructionAvailable, iIP,
        input  iRFData0, iRFData1, iEXEReady,
        output oRFReadAddr0, oRFReadAddr1,
        output oOperation, oDestination, oSource0Value, oSource1Value, oDecodeValid,
        output oReturnAddress, oSubroutineReturn, oProgramEnd, oStackError, oOverrun
    );

    modport slave (
        output iInstruction, iInstructionAvailable, iIP,
        output iRFData0, iRFData1, iEXEReady,
        input  oRFReadAddr0, oRFReadAddr1,
        input  oOperation, oDestination, oSource0Value, oSource1Value, oDecodeValid,
        input  oReturnAddress, oSubroutineReturn, oProgramEnd, oStackError, oOverrun
    );
endinterface

// File: rtl/instruction_decode.sv
// Instruction decode stage: captures fetched instructions, reads both source
// operands from the register file, presents the decoded operation to EXE on a
// valid/ready handshake and maintains the subroutine return-address stack.
module instruction_decode #(
    parameter int              INSTR_W     = 64,
    parameter int              OP_W        = 16,
    parameter int              ADDR_W      = 16,
    parameter int              DATA_W      = 96,
    parameter int              STACK_DEPTH = 4,
    parameter logic [OP_W-1:0] OP_CALL     = 16'h0030,
    parameter logic [OP_W-1:0] OP_RETURN   = 16'h0031
) (
    input logic                  Clock,
    input logic                  Reset,
    instruction_decode_if.master bus
);

    localparam int PTR_W = $clog2(STACK_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {
        IDLE,
        READ,
        LATCH,
        VALID
    } state_t;

    state_t              state_q, state_d;
    logic [INSTR_W-1:0]  instr_q;
    logic [15:0]         rfAddr0_q, rfAddr1_q;
    logic [DATA_W-1:0]   src0_q, src1_q;
    logic [ADDR_W-1:0]   stack_q [STACK_DEPTH];
    logic [CNT_W-1:0]    count_q;
    logic [ADDR_W-1:0]   retAddr_q;
    logic                subRet_q, progEnd_q, stackErr_q, overrun_q;

    logic                transfer, capture;
    logic [OP_W-1:0]     newOp;
    logic                newIsCall, newIsReturn, newIsStackOp;
    logic                stackFull, stackEmpty;
    logic [PTR_W-1:0]    pushIdx, popIdx;

    // A new instruction may be taken when idle or in the very cycle the
    // current operation hands off to EXE, which gives back-to-back issue.
    assign transfer     = (state_q == VALID) && bus.iEXEReady;
    assign capture      = bus.iInstructionAvailable && ((state_q == IDLE) || transfer);
    assign newOp        = bus.iInstruction[INSTR_W-1 -: OP_W];
    assign newIsCall    = (newOp == OP_CALL);
    assign newIsReturn  = (newOp == OP_RETURN);
    assign newIsStackOp = newIsCall || newIsReturn;
    assign stackFull    = (count_q == CNT_W'(STACK_DEPTH));
    assign stackEmpty   = (count_q == '0);
    assign pushIdx      = count_q[PTR_W-1:0];
    assign popIdx       = PTR_W'(count_q - CNT_W'(1));

    // Next-state logic; a capture overrides whatever the current state implies
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = IDLE;
            READ:    state_d = LATCH;
            LATCH:   state_d = VALID;
            VALID:   if (transfer) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (capture) begin
            state_d = newIsStackOp ? VALID : READ;
        end
    end

    // State register
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Instruction, operand, read-address and flag registers
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            instr_q    <= '0;
            rfAddr0_q  <= '0;
            rfAddr1_q  <= '0;
            src0_q     <= '0;
            src1_q     <= '0;
            retAddr_q  <= '0;
            subRet_q   <= 1'b0;
            progEnd_q  <= 1'b0;
            stackErr_q <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            subRet_q  <= 1'b0;
            progEnd_q <= 1'b0;
            if (bus.iInstructionAvailable && !capture) begin
                overrun_q <= 1'b1;
            end
            if (capture) begin
                instr_q <= bus.iInstruction;
                if (newIsStackOp) begin
                    src0_q <= '0;
                    src1_q <= '0;
                end else begin
                    rfAddr0_q <= bus.iInstruction[15:0];
                    rfAddr1_q <= bus.iInstruction[31:16];
                end
                if (newIsCall && stackFull) begin
                    stackErr_q <= 1'b1;
                end
                if (newIsReturn) begin
                    if (!stackEmpty) begin
                        retAddr_q <= stack_q[popIdx];
                        subRet_q  <= 1'b1;
                    end else begin
                        progEnd_q <= 1'b1;
                    end
                end
            end
            if (state_q == LATCH) begin
                src0_q <= bus.iRFData0;
                src1_q <= bus.iRFData1;
            end
        end
    end

    // Return-address stack: push on CALL with room, pop on RETURN with entries
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            count_q <= '0;
            for (int i = 0; i < STACK_DEPTH; i++) begin
                stack_q[i] <= '0;
            end
        end else if (capture && newIsCall && !stackFull) begin
            stack_q[pushIdx] <= bus.iIP + ADDR_W'(1);
            count_q          <= count_q + CNT_W'(1);
        end else if (capture && newIsReturn && !stackEmpty) begin
            count_q <= count_q - CNT_W'(1);
        end
    end

    assign bus.oOperation        = instr_q[INSTR_W-1 -: OP_W];
    assign bus.oDestination      = instr_q[47:32];
    assign bus.oSource0Value     = src0_q;
    assign bus.oSource1Value     = src1_q;
    assign bus.oDecodeValid      = (state_q == VALID);
    assign bus.oRFReadAddr0      = rfAddr0_q;
    assign bus.oRFReadAddr1      = rfAddr1_q;
    assign bus.oReturnAddress    = retAddr_q;
    assign bus.oSubroutineReturn = subRet_q;
    assign bus.oProgramEnd       = progEnd_q;
    assign bus.oStackError       = stackErr_q;
    assign bus.oOverrun          = overrun_q;

endmodule

// File: tb/tb_instruction_decode.sv
// Testbench for instruction_decode: a register-file model, a scoreboard of
// expected decoded operations checked at every EXE transfer, and one task per
// scenario with its own cycle-exact checks.
module tb_instruction_decode;

    localparam logic [15:0] OP_CALL   = 16'h0030;
    localparam logic [15:0] OP_RETURN = 16'h0031;

    typedef struct {
        logic [15:0] op;
        logic [15:0] dest;
        logic [95:0] s0;
        logic [95:0] s1;
        logic [15:0] retAddr;
    } exp_t;

    logic        Clock = 1'b0;
    logic        Reset;
    exp_t        sbQueue[$];
    logic [15:0] modelStack[$];
    logic [15:0] modelRetAddr = 16'h0;
    int          checks = 0;
    int          failures = 0;

    instruction_decode_if bus();

    instruction_decode dut (
        .Clock (Clock),
        .Reset (Reset),
        .bus   (bus)
    );

    always #5 Clock = ~Clock;

    // Deterministic register-file contents derived from the address
    function automatic logic [95:0] rfVal(input logic [15:0] a);
        return {a, 16'hBEEF, ~a, a ^ 16'h5A5A, 16'h1234 + a, a};
    endfunction

    // Register file with one-cycle read latency
    always @(posedge Clock) begin
        bus.iRFData0 <= rfVal(bus.oRFReadAddr0);
        bus.iRFData1 <= rfVal(bus.oRFReadAddr1);
    end

    // Scoreboard: every EXE transfer must match the oldest expected operation
    always @(negedge Clock) begin
        exp_t e;
        if (!Reset && bus.oDecodeValid === 1'b1 && bus.iEXEReady === 1'b1) begin
            checks++;
            if (sbQueue.size() == 0) begin
                failures++;
                $display("[TB] FAIL transfer_unexpected got op=%h dest=%h, required no transfer", bus.oOperation, bus.oDestination);
            end else begin
                e = sbQueue.pop_front();
                if (bus.oOperation !== e.op || bus.oDestination !== e.dest || bus.oSource0Value !== e.s0 ||
                    bus.oSource1Value !== e.s1 || bus.oReturnAddress !== e.retAddr) begin
                    failures++;
                    $display("[TB] FAIL transfer got op=%h dest=%h s0=%h s1=%h ret=%h, required op=%h dest=%h s0=%h s1=%h ret=%h",
                             bus.oOperation, bus.oDestination, bus.oSource0Value, bus.oSource1Value, bus.oReturnAddress,
                             e.op, e.dest, e.s0, e.s1, e.retAddr);
                end
            end
        end
    end

    // Drives one instruction for one clock starting at posedge+1; when the
    // decoder is expected to take it, the stack model and scoreboard are updated.
    task automatic applyStimulus(input logic [63:0] instr, input logic [15:0] ip, input bit taken);
        exp_t e;
        bus.iInstruction          = instr;
        bus.iIP                   = ip;
        bus.iInstructionAvailable = 1'b1;
        if (taken) begin
            e.op   = instr[63:48];
            e.dest = instr[47:32];
            if (instr[63:48] == OP_CALL || instr[63:48] == OP_RETURN) begin
                e.s0 = '0;
                e.s1 = '0;
                if (instr[63:48] == OP_CALL && modelStack.size() < 4) begin
                    modelStack.push_back(ip + 16'd1);
                end
                if (instr[63:48] == OP_RETURN && modelStack.size() > 0) begin
                    modelRetAddr = modelStack.pop_back();
                end
            end else begin
                e.s0 = rfVal(instr[15:0]);
                e.s1 = rfVal(instr[31:16]);
            end
            e.retAddr = modelRetAddr;
            sbQueue.push_back(e);
        end
        @(posedge Clock);
        #1;
        bus.iInstructionAvailable = 1'b0;
    endtask

    task automatic test_reset();
        Reset = 1'b1;
        repeat (2) @(posedge Clock);
        #1;
        checks++;
        if ({bus.oDecodeValid, bus.oSubroutineReturn, bus.oProgramEnd, bus.oStackError, bus.oOverrun} !== 5'b0) begin
            failures++;
            $display("[TB] FAIL reset_flags got %b, required 00000",
                     {bus.oDecodeValid, bus.oSubroutineReturn, bus.oProgramEnd, bus.oStackError, bus.oOverrun});
        end
        checks++;
        if (bus.oOperation !== 16'h0 || bus.oDestination !== 16'h0 || bus.oReturnAddress !== 16'h0) begin
            failures++;
            $display("[TB] FAIL reset_fields got op=%h dest=%h ret=%h, required 0", bus.oOperation, bus.oDestination, bus.oReturnAddress);
        end
        checks++;
        if (bus.oSource0Value !== 96'h0 || bus.oSource1Value !== 96'h0 || bus.oRFReadAddr0 !== 16'h0 || bus.oRFReadAddr1 !== 16'h0) begin
            failures++;
            $display("[TB] FAIL reset_operands got s0=%h s1=%h a0=%h a1=%h, required 0",
                     bus.oSource0Value, bus.oSource1Value, bus.oRFReadAddr0, bus.oRFReadAddr1);
        end
        Reset = 1'b0;
    endtask

    task automatic test_register_op();
        bus.iEXEReady = 1'b0;
        applyStimulus(64'h0001_0005_0003_0002, 16'h0, 1'b1);
        @(negedge Clock);
        checks++;
        if (bus.oRFReadAddr0 !== 16'd2 || bus.oRFReadAddr1 !== 16'd3 || bus.oDecodeValid !== 1'b0) begin
            failures++;
            $display("[TB] FAIL regop_read got a0=%h a1=%h valid=%b, required a0=2 a1=3 valid=0",
                     bus.oRFReadAddr0, bus.oRFReadAddr1, bus.oDecodeValid);
        end
        @(posedge Clock);
        @(negedge Clock);
        checks++;
        if (bus.oDecodeValid !== 1'b0) begin
            failures++;
            $display("[TB] FAIL regop_latch_valid got %b, required 0", bus.oDecodeValid);
        end
        for (int i = 0; i < 4; i++) begin
            @(posedge Clock);
            @(negedge Clock);
            checks++;
            if (bus.oDecodeValid !== 1'b1 || bus.oOperation !== 16'h1 || bus.oDestination !== 16'h5 ||
                bus.oSource0Value !== rfVal(16'd2) || bus.oSource1Value !== rfVal(16'd3)) begin
                failures++;
                $display("[TB] FAIL regop_hold%0d got valid=%b op=%h dest=%h s0=%h s1=%h, required valid=1 op=1 dest=5 s0=%h s1=%h",
                         i, bus.oDecodeValid, bus.oOperation, bus.oDestination, bus.oSource0Value, bus.oSource1Value,
                         rfVal(16'd2), rfVal(16'd3));
            end
        end
        @(posedge Clock);
        #1;
        bus.iEXEReady = 1'b1;
        @(posedge Clock);
        #1;
        checks++;
        if (bus.oDecodeValid !== 1'b0 || sbQueue.size() != 0) begin
            failures++;
            $display("[TB] FAIL regop_transfer got valid=%b pending=%0d, required valid=0 pending=0", bus.oDecodeValid, sbQueue.size());
        end
    endtask

    task automatic test_nested_calls();
        logic [15:0] expRet [2];
        expRet[0] = 16'h0021;
        expRet[1] = 16'h0011;
        bus.iEXEReady = 1'b1;
        applyStimulus({OP_CALL, 48'h0}, 16'h0010, 1'b1);
        @(posedge Clock);
        #1;
        applyStimulus({OP_CALL, 48'h0}, 16'h0020, 1'b1);
        @(posedge Clock);
        #1;
        for (int i = 0; i < 2; i++) begin
            applyStimulus({OP_RETURN, 48'h0}, 16'h0030, 1'b1);
            @(negedge Clock);
            checks++;
            if (bus.oSubroutineReturn !== 1'b1 || bus.oProgramEnd !== 1'b0 || bus.oReturnAddress !== expRet[i]) begin
                failures++;
                $display("[TB] FAIL nested_return%0d got sr=%b pe=%b ret=%h, required sr=1 pe=0 ret=%h",
                         i, bus.oSubroutineReturn, bus.oProgramEnd, bus.oReturnAddress, expRet[i]);
            end
            @(posedge Clock);
            @(negedge Clock);
            checks++;
            if (bus.oSubroutineReturn !== 1'b0) begin
                failures++;
                $display("[TB] FAIL nested_strobe_width%0d got %b, required 0", i, bus.oSubroutineReturn);
            end
            @(posedge Clock);
            #1;
        end
    endtask

    task automatic test_stack_overflow();
        bus.iEXEReady = 1'b1;
        for (int i = 0; i < 5; i++) begin
            applyStimulus({OP_CALL, 48'h0}, 16'h0100 + 16'(i), 1'b1);
            @(negedge Clock);
            checks++;
            if (bus.oStackError !== (i == 4)) begin
                failures++;
                $display("[TB] FAIL overflow_call%0d got err=%b, required %b", i, bus.oStackError, (i == 4));
            end
            @(posedge Clock);
            #1;
        end
        for (int i = 0; i < 5; i++) begin
            applyStimulus({OP_RETURN, 48'h0}, 16'h0200, 1'b1);
            @(negedge Clock);
            checks++;
            if (i < 4) begin
                if (bus.oSubroutineReturn !== 1'b1 || bus.oProgramEnd !== 1'b0 ||
                    bus.oReturnAddress !== 16'h0104 - 16'(i) || bus.oStackError !== 1'b1) begin
                    failures++;
                    $display("[TB] FAIL overflow_pop%0d got sr=%b pe=%b ret=%h err=%b, required sr=1 pe=0 ret=%h err=1",
                             i, bus.oSubroutineReturn, bus.oProgramEnd, bus.oReturnAddress, bus.oStackError, 16'h0104 - 16'(i));
                end
            end else begin
                if (bus.oSubroutineReturn !== 1'b0 || bus.oProgramEnd !== 1'b1 ||
                    bus.oReturnAddress !== 16'h0101 || bus.oStackError !== 1'b1) begin
                    failures++;
                    $display("[TB] FAIL overflow_end got sr=%b pe=%b ret=%h err=%b, required sr=0 pe=1 ret=0101 err=1",
                             bus.oSubroutineReturn, bus.oProgramEnd, bus.oReturnAddress, bus.oStackError);
                end
            end
            @(posedge Clock);
            #1;
        end
    endtask

    task automatic test_wrap();
        bus.iEXEReady = 1'b1;
        applyStimulus({OP_CALL, 48'h0}, 16'hFFFF, 1'b1);
        @(posedge Clock);
        #1;
        applyStimulus({OP_RETURN, 48'h0}, 16'h0005, 1'b1);
        @(negedge Clock);
        checks++;
        if (bus.oReturnAddress !== 16'h0000 || bus.oSubroutineReturn !== 1'b1) begin
            failures++;
            $display("[TB] FAIL wrap got ret=%h sr=%b, required ret=0000 sr=1", bus.oReturnAddress, bus.oSubroutineReturn);
        end
        @(posedge Clock);
        #1;
    endtask

    task automatic test_overrun();
        bus.iEXEReady = 1'b1;
        checks++;
        if (bus.oOverrun !== 1'b0) begin
            failures++;
            $display("[TB] FAIL overrun_initial got %b, required 0", bus.oOverrun);
        end
        applyStimulus(64'h0002_0007_0009_0004, 16'h0050, 1'b1);
        @(posedge Clock);
        #1;
        applyStimulus(64'h0003_0008_000A_000B, 16'h0051, 1'b0);
        @(negedge Clock);
        checks++;
        if (bus.oOverrun !== 1'b1 || bus.oDecodeValid !== 1'b1 || bus.oOperation !== 16'h2 || bus.oRFReadAddr0 !== 16'h4) begin
            failures++;
            $display("[TB] FAIL overrun_drop got ovr=%b valid=%b op=%h a0=%h, required ovr=1 valid=1 op=2 a0=4",
                     bus.oOverrun, bus.oDecodeValid, bus.oOperation, bus.oRFReadAddr0);
        end
        @(posedge Clock);
        @(negedge Clock);
        checks++;
        if (bus.oDecodeValid !== 1'b0 || bus.oOverrun !== 1'b1) begin
            failures++;
            $display("[TB] FAIL overrun_after got valid=%b ovr=%b, required valid=0 ovr=1", bus.oDecodeValid, bus.oOverrun);
        end
        @(posedge Clock);
        #1;
    endtask

    task automatic test_back_to_back();
        bus.iEXEReady = 1'b1;
        applyStimulus({OP_RETURN, 48'h0}, 16'h0060, 1'b1);
        fork
            applyStimulus(64'h0004_0009_0006_0005, 16'h0061, 1'b1);
            begin
                @(negedge Clock);
                checks++;
                if (bus.oDecodeValid !== 1'b1 || bus.oProgramEnd !== 1'b1 || bus.oSubroutineReturn !== 1'b0) begin
                    failures++;
                    $display("[TB] FAIL b2b_return got valid=%b pe=%b sr=%b, required valid=1 pe=1 sr=0",
                             bus.oDecodeValid, bus.oProgramEnd, bus.oSubroutineReturn);
                end
            end
        join
        @(negedge Clock);
        checks++;
        if (bus.oDecodeValid !== 1'b0 || bus.oRFReadAddr0 !== 16'h5 || bus.oRFReadAddr1 !== 16'h6) begin
            failures++;
            $display("[TB] FAIL b2b_read got valid=%b a0=%h a1=%h, required valid=0 a0=5 a1=6",
                     bus.oDecodeValid, bus.oRFReadAddr0, bus.oRFReadAddr1);
        end
        @(posedge Clock);
        @(posedge Clock);
        @(negedge Clock);
        checks++;
        if (bus.oDecodeValid !== 1'b1) begin
            failures++;
            $display("[TB] FAIL b2b_latency got valid=%b, required 1", bus.oDecodeValid);
        end
        @(posedge Clock);
        #1;
    endtask

    task automatic test_reset_mid();
        bus.iEXEReady = 1'b1;
        applyStimulus({OP_CALL, 48'h0}, 16'h0040, 1'b1);
        @(posedge Clock);
        #1;
        bus.iEXEReady = 1'b0;
        applyStimulus(64'h0005_000A_0001_0002, 16'h0041, 1'b1);
        @(posedge Clock);
        #1;
        Reset = 1'b1;
        sbQueue.delete();
        modelStack.delete();
        modelRetAddr = 16'h0;
        #1;
        checks++;
        if (bus.oDecodeValid !== 1'b0 || bus.oOperation !== 16'h0 || bus.oRFReadAddr0 !== 16'h0 ||
            bus.oStackError !== 1'b0 || bus.oOverrun !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset_mid got valid=%b op=%h a0=%h err=%b ovr=%b, required all 0",
                     bus.oDecodeValid, bus.oOperation, bus.oRFReadAddr0, bus.oStackError, bus.oOverrun);
        end
        @(posedge Clock);
        #1;
        Reset = 1'b0;
        bus.iEXEReady = 1'b1;
        applyStimulus({OP_RETURN, 48'h0}, 16'h0070, 1'b1);
        @(negedge Clock);
        checks++;
        if (bus.oProgramEnd !== 1'b1 || bus.oSubroutineReturn !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset_stack_empty got pe=%b sr=%b, required pe=1 sr=0", bus.oProgramEnd, bus.oSubroutineReturn);
        end
        @(posedge Clock);
        #1;
        applyStimulus(64'h0006_000B_000C_000D, 16'h0071, 1'b1);
        for (int i = 0; i < 10 && bus.oDecodeValid !== 1'b1; i++) begin
            @(negedge Clock);
        end
        checks++;
        if (bus.oDecodeValid !== 1'b1) begin
            failures++;
            $display("[TB] FAIL reset_first_op got valid=%b, required 1 within 10 cycles", bus.oDecodeValid);
        end
        @(posedge Clock);
        #1;
    endtask

    // Watchdog so the run always terminates
    initial begin
        #200000;
        $display("[TB] FAIL watchdog got timeout, required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        Reset                     = 1'b1;
        bus.iInstruction          = '0;
        bus.iInstructionAvailable = 1'b0;
        bus.iIP                   = '0;
        bus.iEXEReady             = 1'b0;
        test_reset();
        test_register_op();
        test_nested_calls();
        test_stack_overflow();
        test_wrap();
        test_overrun();
        test_back_to_back();
        test_reset_mid();
        checks++;
        if (sbQueue.size() != 0) begin
            failures++;
            $display("[TB] FAIL scoreboard_drain got pending=%0d, required 0", sbQueue.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/instruction_decode.md
# instruction_decode

Instruction decode stage sitting directly downstream of the instruction fetch unit and upstream of EXE. It captures each fetched instruction when the fetch unit announces it, splits it into opcode, destination and source fields, and reads both source operands from the register file. It hands a fully decoded operation to EXE over a valid/ready handshake. It also owns the subroutine return-address stack: it pushes on CALL and pops on RETURN, and supplies the fetch unit with the return address and a return strobe.

## Interface
- INSTR_W, 64, instruction width; fields are opcode [63:48], destination [47:32], source1 [31:16], source0 [15:0]
- OP_W, 16, opcode width
- ADDR_W, 16, instruction ROM address width
- DATA_W, 96, register-file word width (3 × 32-bit components)
- STACK_DEPTH, 4, return-address stack entries, power of two ≥ 2
- OP_CALL, 16'h0030, CALL opcode
- OP_RETURN, 16'h0031, RETURN opcode
- Clock  in  1  single clock, all state on posedge
- Reset  in  1  asynchronous, active-high; clears every register
- iInstruction  in  INSTR_W  instruction from fetch unit
- iInstructionAvailable  in  1  iInstruction and iIP valid this cycle
- iIP  in  ADDR_W  address of iInstruction
- oRFReadAddr0, oRFReadAddr1  out  16  register-file read addresses (source0, source1)
- iRFData0, iRFData1  in  DATA_W  register-file read data, valid one cycle after address
- oOperation  out  OP_W  decoded opcode
- oDestination  out  16  destination field
- oSource0Value, oSource1Value  out  DATA_W  operand values
- oDecodeValid  out  1  decoded operation valid for EXE
- iEXEReady  in  1  EXE accepts operation this cycle
- oReturnAddress  out  ADDR_W  address popped by the last RETURN
- oSubroutineReturn  out  1  one-cycle strobe: RETURN popped the stack
- oProgramEnd  out  1  one-cycle strobe: RETURN with empty stack
- oStackError  out  1  sticky: CALL on full stack
- oOverrun  out  1  sticky: instruction arrived while busy

## Operation
- The FSM has four states: IDLE, READ, LATCH and VALID.
- **IDLE:** on iInstructionAvailable, capture iInstruction into rInstr.
  - CALL or RETURN: go to VALID with both source values forced to 0. No register-file read is done.
  - Any other opcode: go to READ.
- **READ:** oRFReadAddr0/1 = rInstr source0/source1. Go to LATCH.
- **LATCH:** capture iRFData0/1 into oSource0Value/oSource1Value. Go to VALID.
- **VALID:** oDecodeValid = 1. oOperation and oDestination come from rInstr. Outputs hold stable until a transfer.
- **Transfer:** oDecodeValid & iEXEReady at a posedge.
  - Next state is IDLE.
  - If iInstructionAvailable is also high in that cycle, the new instruction is captured at the same edge and handled exactly as in IDLE, giving back-to-back operation.
- iInstructionAvailable in READ or LATCH, or in VALID without a transfer: the instruction is dropped and oOverrun is set.
- oRFReadAddr0/1 hold their last value outside READ.
- **Stack actions** happen at the capture edge only:
  - CALL, stack not full: push (iIP+1) mod 2^ADDR_W.
  - CALL, stack full: no push, oStackError set.
  - RETURN, stack non-empty: pop; oReturnAddress loads the popped entry; oSubroutineReturn pulses in the next cycle.
  - RETURN, stack empty: no pop; oProgramEnd pulses in the next cycle; oReturnAddress unchanged.
- Stack occupancy counter is $clog2(STACK_DEPTH)+1 bits wide, range 0..STACK_DEPTH.
- Sticky flags clear only on Reset.

## Timing
- Reset values:
  - FSM = IDLE, stack empty.
  - All outputs 0: oDecodeValid, oOperation, oDestination, oSource0Value, oSource1Value, oRFReadAddr0/1, oReturnAddress, both strobes, both sticky flags.
- Reset asserted mid-operation (any state) empties the stack and clears all outputs asynchronously. The first instruction after deassertion is decoded normally.
- Latency, from the edge that samples iInstructionAvailable to oDecodeValid high:
  - 3 cycles for register operations (READ, LATCH, VALID).
  - 1 cycle for CALL/RETURN.
- oSubroutineReturn and oProgramEnd assert in the same cycle that oDecodeValid rises for the RETURN.
- Throughput: one register operation per 3 cycles; one CALL/RETURN per cycle with iEXEReady held high.
- oDecodeValid never drops without a transfer.

## Test plan
- **Register op:** instruction 0x0001_0005_0003_0002 with RF[2]=A, RF[3]=B.
  - oRFReadAddr0=2 and oRFReadAddr1=3 during READ.
  - oDecodeValid rises 3 cycles after capture with oOperation=1, oDestination=5, oSource0Value=A, oSource1Value=B.
  - Held for 4 cycles with iEXEReady=0, then transfers.
- **Nested calls:** CALL at iIP=0x10, then CALL at 0x20, then RETURN, then RETURN.
  - oReturnAddress is 0x21, then 0x11.
  - oSubroutineReturn pulses twice.
  - oProgramEnd stays 0.
- **Stack overflow:** 5 CALLs with STACK_DEPTH=4.
  - oStackError sets on the 5th and stays set.
  - Next 4 RETURNs pop in LIFO order; the 5th RETURN pulses oProgramEnd.
- **Wrap-around:** CALL at iIP=0xFFFF then RETURN → oReturnAddress=0x0000.
- **Overrun:** iInstructionAvailable pulsed during LATCH.
  - That instruction is dropped and oOverrun=1.
  - The current operation completes unchanged.
- **Back-to-back and reset:** RETURN followed by a register op with iInstructionAvailable high during the transfer cycle.
  - No idle cycle between them.
  - Asserting Reset in LATCH clears oDecodeValid and empties the stack immediately.
